// File: rtl/i2c_read2_master.sv
// Purpose: I2C master that issues START, address+R, reads two bytes (ACK, then NACK), then STOP.
// Latency: 58*DIV_HALF clk from accepted start to done (22*DIV_HALF on address NACK).
// Backpressure: start is accepted only in IDLE; pulses while busy are dropped.
//
// Ports: clk/rst_n (async active-low); start + slave_addr request a read;
//        scl (push-pull), sda_oe (1 = pull SDA low), sda_in (line sample);
//        busy, done (1-clk pulse), addr_nack (sticky until next start), data1/data2.
module i2c_read2_master #(
    parameter int unsigned DIV_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] slave_addr,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       busy,
    output logic       done,
    output logic       addr_nack,
    output logic [7:0] data1,
    output logic [7:0] data2
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, RD1, ACK1, RD2, NACK2, STOP, DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] half_cnt;
    logic [1:0] half_idx;   // bit states: 0 = SCL low half, 1 = high half; STOP: 0..2
    logic [2:0] bit_cnt;
    logic [6:0] addr_r;
    logic [7:0] rx_sr;

    logic       half_end;
    logic       bit_state;
    logic       bit_end;
    logic [7:0] addr_byte;

    assign half_end  = (half_cnt == 8'(DIV_HALF - 1));
    assign bit_state = (state == ADDR) || (state == ADDR_ACK) || (state == RD1) ||
                       (state == ACK1) || (state == RD2) || (state == NACK2);
    // Last clk of the high half: sda_in is sampled here and the bit advances.
    assign bit_end   = bit_state && half_end && (half_idx == 2'd1);
    assign addr_byte = {addr_r, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Bus outputs are decoded from registered state so a reset releases the bus at once.
    always_comb begin
        state_nxt = state;
        scl       = 1'b1;
        sda_oe    = 1'b0;
        case (state)
            IDLE:     if (start) state_nxt = START;
            START: begin
                sda_oe = 1'b1;
                if (half_end) state_nxt = ADDR;
            end
            ADDR: begin
                scl    = half_idx[0];
                sda_oe = ~addr_byte[bit_cnt];
                if (bit_end && bit_cnt == 3'd0) state_nxt = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl = half_idx[0];
                if (bit_end) state_nxt = sda_in ? STOP : RD1;
            end
            RD1: begin
                scl = half_idx[0];
                if (bit_end && bit_cnt == 3'd0) state_nxt = ACK1;
            end
            ACK1: begin
                scl    = half_idx[0];
                sda_oe = 1'b1;
                if (bit_end) state_nxt = RD2;
            end
            RD2: begin
                scl = half_idx[0];
                if (bit_end && bit_cnt == 3'd0) state_nxt = NACK2;
            end
            NACK2: begin
                scl = half_idx[0];
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                // SCL low/SDA low, SCL high/SDA low, then SDA released (STOP + bus-free)
                scl    = (half_idx != 2'd0);
                sda_oe = (half_idx != 2'd2);
                if (half_end && half_idx == 2'd2) state_nxt = DONE;
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt  <= 8'd0;
            half_idx  <= 2'd0;
            bit_cnt   <= 3'd0;
            addr_r    <= 7'd0;
            rx_sr     <= 8'd0;
            addr_nack <= 1'b0;
            data1     <= 8'h00;
            data2     <= 8'h00;
        end else if (state == IDLE || state == DONE) begin
            half_cnt <= 8'd0;
            half_idx <= 2'd0;
            bit_cnt  <= 3'd0;
            if (state == IDLE && start) begin
                addr_r    <= slave_addr;
                addr_nack <= 1'b0;
            end
        end else begin
            half_cnt <= half_end ? 8'd0 : half_cnt + 8'd1;
            if (half_end) begin
                case (state)
                    START: begin
                        half_idx <= 2'd0;
                        bit_cnt  <= 3'd7;
                    end
                    STOP:    half_idx <= half_idx + 2'd1;
                    default: half_idx <= {1'b0, ~half_idx[0]};
                endcase
            end
            if (bit_end) begin
                // Byte states count 7..0; single-bit ACK states preload 7 for the next byte.
                if (state == ADDR || state == RD1 || state == RD2)
                    bit_cnt <= bit_cnt - 3'd1;
                else
                    bit_cnt <= 3'd7;
                if (state == ADDR_ACK && sda_in)
                    addr_nack <= 1'b1;
                if (state == RD1 || state == RD2)
                    rx_sr <= {rx_sr[6:0], sda_in};
                if (state == RD1 && bit_cnt == 3'd0)
                    data1 <= {rx_sr[6:0], sda_in};
                if (state == RD2 && bit_cnt == 3'd0)
                    data2 <= {rx_sr[6:0], sda_in};
            end
        end
    end

endmodule

// File: tb/tb_i2c_read2_master.sv
// Purpose: directed bench for i2c_read2_master with an I2C slave model and bus protocol checker.
// Latency: checks 232-cycle full reads and 88-cycle address-NACK reads at DIV_HALF=4.
// Backpressure: exercises start while busy and start in the first IDLE cycle after done.
module tb_i2c_read2_master;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] slave_addr;
    logic       scl;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       addr_nack;
    logic [7:0] data1;
    logic [7:0] data2;

    logic       slave_pull;
    wire        sda = ~(sda_oe | slave_pull);

    int errors = 0;
    int checks = 0;

    i2c_read2_master #(.DIV_HALF(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .slave_addr(slave_addr),
        .scl(scl), .sda_oe(sda_oe), .sda_in(sda), .busy(busy), .done(done),
        .addr_nack(addr_nack), .data1(data1), .data2(data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model: bit period k begins at each SCL fall after START (k = 0 first address bit).
    int         k = -1;
    logic       s_en = 1'b1;
    logic [7:0] s_b1 = 8'h00;
    logic [7:0] s_b2 = 8'h00;
    logic [27:0] bus_bits = '0;

    initial begin
        slave_pull = 1'b0;
        forever begin
            @(negedge scl);
            k = k + 1;
            if (s_en && k == 8)                slave_pull = 1'b1;
            else if (s_en && k >= 9 && k <= 16)  slave_pull = ~s_b1[16 - k];
            else if (s_en && k >= 18 && k <= 25) slave_pull = ~s_b2[25 - k];
            else                               slave_pull = 1'b0;
        end
    end

    initial forever begin
        @(negedge sda);
        if (scl) k = -1;
    end

    initial forever begin
        @(posedge scl);
        if (k >= 0 && k <= 27) bus_bits[k] = sda;
    end

    // Protocol checker: SDA may move while SCL stays high only as START (bus free) or STOP.
    int   stop_cnt = 0;
    int   done_cnt = 0;
    logic bus_free = 1'b1;
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    logic legal;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            bus_free = 1'b1;
        end else begin
            if (prev_scl && scl && (sda !== prev_sda)) begin
                legal = (!sda && bus_free) || (sda && !bus_free);
                checks++;
                assert (legal) else begin
                    errors++;
                    $error("FAIL sda_while_scl_high: observed sda %0b->%0b expected stable (bus_free=%0b) at %0t",
                           prev_sda, sda, bus_free, $time);
                end
                if (legal) begin
                    bus_free = sda;
                    if (sda) stop_cnt++;
                end
            end
            if (done) done_cnt++;
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // Drive start now (away from an edge); the next rising edge accepts it.
    task automatic do_start(input logic [6:0] a);
        start      = 1'b1;
        slave_addr = a;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1 cyc++;
            if (done) break;
        end
    endtask

    task automatic wait_bit(input int kk);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (k == kk) break;
        end
    endtask

    task automatic chk_read(input string tag, input logic [6:0] a, input logic [7:0] b1,
                            input logic [7:0] b2);
        chk({tag, "_addr_bits"}, 32'(bus_bits[7:0]), 32'({bus_bits[7:0]} == 8'h0 ? 8'hx : 8'h0) | 32'(8'h0) | 32'(reverse8({a, 1'b1})));
        chk({tag, "_slave_ack"}, 32'(bus_bits[8]),  32'd0);
        chk({tag, "_master_ack"}, 32'(bus_bits[17]), 32'd0);
        chk({tag, "_master_nack"}, 32'(bus_bits[26]), 32'd1);
        chk({tag, "_data1"}, 32'(data1), 32'(b1));
        chk({tag, "_data2"}, 32'(data2), 32'(b2));
        chk({tag, "_addr_nack"}, 32'(addr_nack), 32'd0);
    endtask

    // bus_bits[0] holds the first (MSB) bit sent, so the expected pattern is bit-reversed.
    function automatic logic [7:0] reverse8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    int cyc;
    int stops0;
    int dones0;

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        slave_addr = 7'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr_nack", 32'(addr_nack), 32'd0);
        chk("rst_data1", 32'(data1), 32'h00);
        chk("rst_data2", 32'(data2), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Normal read: address 0x50 -> bits 1,0,1,0,0,0,0,1
        s_en = 1'b1; s_b1 = 8'hA8; s_b2 = 8'h39;
        stops0 = stop_cnt;
        do_start(7'h50);
        chk("norm_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        chk("norm_latency", 32'(cyc), 32'd232);
        chk("norm_busy_at_done", 32'(busy), 32'd0);
        chk("norm_addr_bits", 32'(bus_bits[7:0]), 32'(8'b1000_0101));
        chk_read("norm", 7'h50, 8'hA8, 8'h39);
        chk("norm_stop", 32'(stop_cnt - stops0), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Address NACK: slave never drives
        s_en = 1'b0;
        stops0 = stop_cnt;
        do_start(7'h77);
        wait_done(cyc);
        chk("nack_latency", 32'(cyc), 32'd88);
        chk("nack_flag", 32'(addr_nack), 32'd1);
        chk("nack_ack_bit", 32'(bus_bits[8]), 32'd1);
        chk("nack_data1_kept", 32'(data1), 32'hA8);
        chk("nack_data2_kept", 32'(data2), 32'h39);
        chk("nack_stop", 32'(stop_cnt - stops0), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Start while busy (mid-RD1) is ignored
        s_en = 1'b1; s_b1 = 8'h3C; s_b2 = 8'hC5;
        dones0 = done_cnt;
        do_start(7'h50);
        chk("busy_nack_cleared", 32'(addr_nack), 32'd0);
        wait_bit(12);
        do_start(7'h12);
        wait_done(cyc);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_one_done", 32'(done_cnt - dones0), 32'd1);
        chk_read("busy", 7'h50, 8'h3C, 8'hC5);

        // Reset during RD2
        s_b1 = 8'h5A; s_b2 = 8'hC3;
        do_start(7'h2D);
        wait_bit(20);
        rst_n = 1'b0;
        slave_pull = 1'b0;
        #1;
        chk("mid_rst_scl", 32'(scl), 32'd1);
        chk("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data1", 32'(data1), 32'h00);
        chk("mid_rst_data2", 32'(data2), 32'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_start(7'h2D);
        wait_done(cyc);
        chk("post_rst_latency", 32'(cyc), 32'd232);
        chk_read("post_rst", 7'h2D, 8'h5A, 8'hC3);

        // Back-to-back: second start in the IDLE cycle right after done
        repeat (2) @(posedge clk);
        #1;
        s_b1 = 8'h81; s_b2 = 8'h7E;
        do_start(7'h3C);
        wait_done(cyc);
        chk("b2b_first_data1", 32'(data1), 32'h81);
        s_b1 = 8'hFF; s_b2 = 8'h00;
        @(posedge clk);
        #1;
        do_start(7'h50);
        chk("b2b_accepted", 32'(busy), 32'd1);
        wait_done(cyc);
        chk("b2b_latency", 32'(cyc), 32'd232);
        chk_read("b2b", 7'h50, 8'hFF, 8'h00);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_read2_master.md
I2C_READ2_MASTER -- requirements
Module: i2c_read2_master

Interface
REQ-001 SHALL have parameter DIV_HALF, default 4; it sets the number of clk cycles per SCL half-period and is legal for values 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle request to begin a read transaction.
REQ-005 SHALL have port slave_addr, input, 7 bits: the target address, captured when start is accepted.
REQ-006 SHALL have port scl, output, 1 bit: the generated SCL (push-pull).
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases SDA to the pull-up (open-drain; top level does the assign sda = sda_oe ? 0 : z).
REQ-008 SHALL have port sda_in, input, 1 bit: the sampled SDA line.
REQ-009 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse at transaction end.
REQ-011 SHALL have port addr_nack, output, 1 bit: set when the slave did not ACK the address; it holds until the next accepted start.
REQ-012 SHALL have port data1, output, 8 bits: the first byte read from the slave.
REQ-013 SHALL have port data2, output, 8 bits: the second byte read from the slave.

Function
REQ-014 SHALL use the states IDLE, START, ADDR, ADDR_ACK, RD1, ACK1, RD2, NACK2, STOP, and DONE.
REQ-015 SHALL accept start only in IDLE; start SHALL be ignored while busy=1.
REQ-016 On acceptance, SHALL capture slave_addr and go to START.
REQ-017 START: SHALL set sda_oe=1 while scl=1 for one half-period, which forms the START condition.
REQ-018 Each bit period SHALL be one half-period with scl=0 followed by one half-period with scl=1.
REQ-019 Each bit period SHALL update sda_oe on the first clk of the low half and sample sda_in on the last clk of the high half.
REQ-020 ADDR: SHALL send 8 bits MSB first, {slave_addr[6:0], 1'b1} (read bit = 1); a transmitted 1 SHALL mean sda_oe=0.
REQ-021 ADDR_ACK: SHALL release SDA and sample it; 0 means ACK and goes to RD1, 1 means NACK, sets addr_nack, and goes to STOP.
REQ-022 RD1/RD2: SHALL release SDA and shift sda_in into an 8-bit register MSB first over 8 bit periods.
REQ-023 ACK1: SHALL drive sda_oe=1 for one bit period (master ACK); NACK2 SHALL release SDA for one bit period (master NACK).
REQ-024 data1 SHALL update once at the end of RD1, and data2 once at the end of RD2.
REQ-025 On an address NACK, data1 and data2 SHALL retain their previous values.
REQ-026 STOP: SHALL hold scl=0 with sda_oe=1 for one half, then scl=1 with sda_oe=1 for one half, then sda_oe=0 with scl=1 for one half (STOP plus bus-free time).
REQ-027 DONE: SHALL pulse done=1 for one clk, deassert busy in the same cycle, and return to IDLE; a start in the cycle after DONE SHALL be accepted.
REQ-028 Full-read latency SHALL be 58*DIV_HALF clk cycles from the accepting edge to the done pulse; for DIV_HALF=4 that is 232 cycles.
REQ-029 Address-NACK latency SHALL be 22*DIV_HALF clk cycles, i.e. 1+18 START/bit halves plus 3 STOP halves.
REQ-030 scl SHALL be 1 in IDLE.
REQ-031 SDA SHALL change only while scl=0, except at the START and STOP edges.
REQ-032 The half-period counter SHALL count 0..DIV_HALF-1 and wrap; the bit counter SHALL count 7..0.

Reset
REQ-033 While rst_n=0, SHALL force scl=1, sda_oe=0, busy=0, done=0, addr_nack=0, data1=8'h00, data2=8'h00, state IDLE, and all counters 0.
REQ-034 Reset asserted mid-transaction SHALL take effect immediately (asynchronously), releasing the bus without generating a STOP.
REQ-035 The first start accepted after rst_n rises SHALL behave exactly as one accepted from power-up.

Verification
REQ-036 Bench SHALL cover a normal read: DIV_HALF=4, slave_addr=7'h50, slave model ACKs and returns 8'hA8 then 8'h39 -> address bits 1,0,1,0,0,0,0,1 on the bus; master ACK after byte 1 and NACK after byte 2; data1=8'hA8, data2=8'h39, addr_nack=0; done exactly 232 cycles after start.
REQ-037 Bench SHALL cover an address NACK: slave model never drives SDA -> addr_nack=1, data1/data2 unchanged, STOP seen, done 88 cycles after start.
REQ-038 Bench SHALL cover start while busy: a second start pulse mid-RD1 with slave_addr=7'h12 -> ignored; the transaction completes with the original address and only one done pulse.
REQ-039 Bench SHALL cover reset mid-byte: rst_n low during RD2 -> same cycle scl=1, sda_oe=0, busy=0, data1=data2=8'h00; a subsequent read completes normally.
REQ-040 Bench SHALL cover back-to-back reads: start in the cycle after done, second slave bytes 8'hFF/8'h00 -> accepted; data1=8'hFF, data2=8'h00.
REQ-041 Bench SHALL include a protocol checker that flags any SDA transition while scl=1 other than START and STOP, throughout all scenarios.
